alu_operand_loader: RTL and testbench

Upstream feeder for the 8-bit ALU stage. The top-level has only 8 input pins, so operands are narrowed at the pins. This block removes that restriction: a command (select, then full 8-bit A, then full 8-bit B) is accepted as a byte-serial stream over those pins and held stable on the ALU operand inputs. After a programmable settle time it registers the ALU result and carry-out for the output pins.

---
 rtl/alu_operand_loader.sv | 153 +++++++++++++++
 tb/tb_alu_operand_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - byte-serial command loader that feeds the 8-bit ALU and captures its result.
// Optional accumulate chaining is enabled by defining ALU_ACC_CHAIN_EN.
module alu_operand_loader #(
   parameter int WIDTH   = 8,
   parameter int SETTLE  = 1,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [2:0]       op_sel,
   output logic             op_valid,
   output logic [WIDTH-1:0] res_out,
   output logic             res_cout,
   output logic             res_valid,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      GET_B = 2'd2,
      EXEC  = 2'd3
   } state_t;

   state_t           st, st_nxt;
   logic [3:0]       settle_cnt, settle_nxt;
   logic [7:0]       idle_cnt, idle_nxt;
   logic [WIDTH-1:0] op_a_nxt, op_b_nxt, res_out_nxt;
   logic [2:0]       op_sel_nxt;
   logic             op_valid_nxt, res_cout_nxt, res_valid_nxt, busy_nxt, err_nxt;
   logic             idle_expired;

   assign idle_expired = (idle_cnt == 8'(TIMEOUT - 1));
   assign state        = {1'b0, st};

   // All state advances only on enabled cycles; the next-state logic assumes ena=1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         settle_cnt <= '0;
         idle_cnt   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_sel     <= '0;
         op_valid   <= 1'b0;
         res_out    <= '0;
         res_cout   <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else if (ena) begin
         st         <= st_nxt;
         settle_cnt <= settle_nxt;
         idle_cnt   <= idle_nxt;
         op_a       <= op_a_nxt;
         op_b       <= op_b_nxt;
         op_sel     <= op_sel_nxt;
         op_valid   <= op_valid_nxt;
         res_out    <= res_out_nxt;
         res_cout   <= res_cout_nxt;
         res_valid  <= res_valid_nxt;
         busy       <= busy_nxt;
         err        <= err_nxt;
      end
   end

   always_comb begin
      st_nxt        = st;
      settle_nxt    = settle_cnt;
      idle_nxt      = idle_cnt;
      op_a_nxt      = op_a;
      op_b_nxt      = op_b;
      op_sel_nxt    = op_sel;
      op_valid_nxt  = op_valid;
      res_out_nxt   = res_out;
      res_cout_nxt  = res_cout;
      res_valid_nxt = res_valid;
      busy_nxt      = busy;
      err_nxt       = err;

      case (st)
         IDLE: begin
            if (din_valid) begin
               op_sel_nxt    = din[2:0];
               res_valid_nxt = 1'b0;
               err_nxt       = 1'b0;
               idle_nxt      = '0;
               st_nxt        = GET_A;
`ifdef ALU_ACC_CHAIN_EN
               if (din[3] && res_valid) begin
                  op_a_nxt = res_out;
                  st_nxt   = GET_B;
               end
`endif
            end
         end
         GET_A: begin
            if (din_valid) begin
               op_a_nxt = din;
               idle_nxt = '0;
               st_nxt   = GET_B;
            end else if (idle_expired) begin
               err_nxt  = 1'b1;
               idle_nxt = '0;
               st_nxt   = IDLE;
            end else begin
               idle_nxt = idle_cnt + 8'd1;
            end
         end
         GET_B: begin
            // A beat arriving on the expiry cycle takes priority over the timeout.
            if (din_valid) begin
               op_b_nxt     = din;
               op_valid_nxt = 1'b1;
               busy_nxt     = 1'b1;
               settle_nxt   = 4'(SETTLE);
               idle_nxt     = '0;
               st_nxt       = EXEC;
            end else if (idle_expired) begin
               err_nxt  = 1'b1;
               idle_nxt = '0;
               st_nxt   = IDLE;
            end else begin
               idle_nxt = idle_cnt + 8'd1;
            end
         end
         EXEC: begin
            if (settle_cnt == 4'd1) begin
               res_out_nxt   = alu_result;
               res_cout_nxt  = alu_cout;
               res_valid_nxt = 1'b1;
               op_valid_nxt  = 1'b0;
               busy_nxt      = 1'b0;
               settle_nxt    = '0;
               st_nxt        = IDLE;
            end else begin
               settle_nxt = settle_cnt - 4'd1;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench driving two loaders (SETTLE=1 and SETTLE=3) with shared beats.
module tb_alu_operand_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;

   logic [7:0] alu_r1, alu_r3, op_a1, op_a3, op_b1, op_b3, res_out1, res_out3;
   logic       alu_c1, alu_c3, op_valid1, op_valid3, res_cout1, res_cout3;
   logic       res_valid1, res_valid3, busy1, busy3, err1, err3;
   logic [2:0] op_sel1, op_sel3, state1, state3;

   int n_vec = 0;
   int n_miss = 0;
   int ov_cnt1 = 0;
   int ov_cnt3 = 0;
   logic rv_prev1 = 1'b0;
   logic rv_prev3 = 1'b0;
   logic [27:0] q1[$];
   logic [27:0] q3[$];

   always #5 clk = ~clk;

   function automatic logic [8:0] alu_model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         3'd2:    return {1'b0, a} - {1'b0, b};
         3'd3:    return {1'b0, a & b};
         default: return {1'b0, a} + {1'b0, b};
      endcase
   endfunction

   assign {alu_c1, alu_r1} = alu_model(op_sel1, op_a1, op_b1);
   assign {alu_c3, alu_r3} = alu_model(op_sel3, op_a3, op_b3);

   alu_operand_loader #(.WIDTH(8), .SETTLE(1), .TIMEOUT(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
      .alu_result(alu_r1), .alu_cout(alu_c1),
      .op_a(op_a1), .op_b(op_b1), .op_sel(op_sel1), .op_valid(op_valid1),
      .res_out(res_out1), .res_cout(res_cout1), .res_valid(res_valid1),
      .busy(busy1), .err(err1), .state(state1)
   );

   alu_operand_loader #(.WIDTH(8), .SETTLE(3), .TIMEOUT(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
      .alu_result(alu_r3), .alu_cout(alu_c3),
      .op_a(op_a3), .op_b(op_b3), .op_sel(op_sel3), .op_valid(op_valid3),
      .res_out(res_out3), .res_cout(res_cout3), .res_valid(res_valid3),
      .busy(busy3), .err(err3), .state(state3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected entry: {sel, a, b, res, cout}
   task automatic expect_res(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] r, input logic c);
      q1.push_back({s, a, b, r, c});
      q3.push_back({s, a, b, r, c});
   endtask

   always @(negedge clk) begin
      if (op_valid1) ov_cnt1++;
      if (res_valid1 && !rv_prev1) begin
         if (q1.size() == 0) check("dut1 unexpected result", 32'd1, 32'd0);
         else check("dut1 result", {4'h0, op_sel1, op_a1, op_b1, res_out1, res_cout1}, {4'h0, q1.pop_front()});
         check("dut1 op_valid cycles", ov_cnt1, 32'd1);
         ov_cnt1 = 0;
      end
      rv_prev1 = res_valid1;
   end

   always @(negedge clk) begin
      if (op_valid3) ov_cnt3++;
      if (res_valid3 && !rv_prev3) begin
         if (q3.size() == 0) check("dut3 unexpected result", 32'd1, 32'd0);
         else check("dut3 result", {4'h0, op_sel3, op_a3, op_b3, res_out3, res_cout3}, {4'h0, q3.pop_front()});
         check("dut3 op_valid cycles", ov_cnt3, 32'd3);
         ov_cnt3 = 0;
      end
      rv_prev3 = res_valid3;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input logic [7:0] d);
      din = d;
      din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 40; i++) begin
         if (res_valid1 && res_valid3) break;
         tick(1);
      end
      if (i >= 40) check({name, " result timeout"}, 32'd1, 32'd0);
      tick(1);
   endtask

   initial begin
      tick(1);
      check("reset outputs dut1", {op_a1, op_b1, op_sel1, op_valid1, res_out1, res_cout1, res_valid1, busy1, err1, state1}, 32'd0);
      check("reset outputs dut3", {op_a3, op_b3, op_sel3, op_valid3, res_out3, res_cout3, res_valid3, busy3, err3, state3}, 32'd0);
      rst_n = 1'b1;
      ena = 1'b1;
      tick(1);

      expect_res(3'd0, 8'h25, 8'h13, 8'h38, 1'b0);
      beat(8'h00); beat(8'h25); beat(8'h13);
      wait_done("basic");

      expect_res(3'd1, 8'hF0, 8'h20, 8'h10, 1'b1);
      beat(8'h01); beat(8'hF0); beat(8'h20);
      wait_done("carry");

      // Beat during EXEC must be dropped; the following command must decode cleanly.
      expect_res(3'd3, 8'hCC, 8'h0F, 8'h0C, 1'b0);
      beat(8'h03); beat(8'hCC); beat(8'h0F);
      check("busy in exec", {busy1, busy3, state1, state3}, {2'b11, 3'd3, 3'd3});
      beat(8'h07);
      wait_done("busy drop");
      expect_res(3'd2, 8'h50, 8'h20, 8'h30, 1'b0);
      beat(8'h02); beat(8'h50); beat(8'h20);
      wait_done("after drop");

      expect_res(3'd0, 8'h40, 8'h04, 8'h44, 1'b0);
      beat(8'h00); beat(8'h40);
      ena = 1'b0;
      din = 8'h99;
      din_valid = 1'b1;
      tick(10);
      din_valid = 1'b0;
      check("ena freeze state", {state1, state3, err1, err3}, {3'd2, 3'd2, 2'b00});
      ena = 1'b1;
      beat(8'h04);
      wait_done("ena freeze");

      beat(8'h02); beat(8'h55);
      tick(3);
      check("no timeout yet", {err1, err3, state1, state3}, {2'b00, 3'd2, 3'd2});
      tick(1);
      check("timeout", {err1, err3, state1, state3, res_valid1, res_valid3, op_valid1, op_valid3},
            {2'b11, 3'd0, 3'd0, 4'b0000});
      check("timeout keeps op_a", {op_a1, op_a3}, {8'h55, 8'h55});

      expect_res(3'd0, 8'h11, 8'h22, 8'h33, 1'b0);
      beat(8'h00);
      check("sel clears err", {err1, err3}, 2'b00);
      beat(8'h11);
      tick(3);
      beat(8'h22);
      wait_done("beat wins at timeout");

      beat(8'h00); beat(8'hAA);
      check("mid-command state", {state1, state3}, {3'd2, 3'd2});
      #2 rst_n = 1'b0;
      #1;
      check("async reset dut1", {op_a1, op_b1, op_sel1, op_valid1, res_out1, res_cout1, res_valid1, busy1, err1, state1}, 32'd0);
      check("async reset dut3", {op_a3, op_b3, op_sel3, op_valid3, res_out3, res_cout3, res_valid3, busy3, err3, state3}, 32'd0);
      rst_n = 1'b1;
      tick(1);
      expect_res(3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0);
      beat(8'h03); beat(8'hF0); beat(8'h3C);
      wait_done("after reset");

      expect_res(3'd0, 8'h25, 8'h13, 8'h38, 1'b0);
      beat(8'h00); beat(8'h25); beat(8'h13);
      wait_done("chain seed");
`ifdef ALU_ACC_CHAIN_EN
      expect_res(3'd0, 8'h38, 8'h01, 8'h39, 1'b0);
      beat(8'h08); beat(8'h01);
`else
      expect_res(3'd0, 8'h01, 8'h02, 8'h03, 1'b0);
      beat(8'h08); beat(8'h01); beat(8'h02);
`endif
      wait_done("chain");

      tick(2);
      check("dut1 queue drained", q1.size(), 32'd0);
      check("dut3 queue drained", q3.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
